// File: rtl/boxcar_decimator.sv
// boxcar_decimator
//   Accumulate-and-dump decimator. Sums each group of 2**DECIM_LOG2 signed
//   samples, arithmetic-shifts the group sum right by OUT_SHIFT, saturates it
//   to DATA_WIDTH bits and presents it on a valid/ready output register.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; drops any partial group and pending output
//   clear      synchronous; discards the partial group, keeps pending output/sat_count
//   in_valid   input sample valid
//   in_ready   block accepts in_data this cycle
//   in_data    signed input sample
//   out_valid  out_data/out_sat valid
//   out_ready  consumer takes the output this cycle
//   out_data   signed decimated sample
//   out_sat    out_data was clipped to full scale
//   sat_count  saturated outputs since reset, sticks at 16'hFFFF
//
// Build option
//   BOXCAR_DECIMATOR_ROUND_EN: when defined and OUT_SHIFT > 0, adds
//   2**(OUT_SHIFT-1) before the shift (round half up); otherwise truncates.

module boxcar_decimator #(
   parameter int DATA_WIDTH = 16,
   parameter int DECIM_LOG2 = 2,
   parameter int OUT_SHIFT  = DECIM_LOG2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         out_sat,
   output logic [15:0]                  sat_count
);

   localparam int AW = DATA_WIDTH + DECIM_LOG2;
   localparam int RW = AW + 1;

   localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

   // Full-scale limits, sign-extended to the rounding width.
   localparam logic signed [RW-1:0] SAT_MAX =
      {{(DECIM_LOG2 + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
   localparam logic signed [RW-1:0] SAT_MIN =
      {{(DECIM_LOG2 + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

`ifdef BOXCAR_DECIMATOR_ROUND_EN
   localparam logic [RW-1:0] RND_ONE  = {{(RW - 1){1'b0}}, 1'b1};
   localparam logic [RW-1:0] RND_HALF = (OUT_SHIFT == 0) ? '0 : ((RND_ONE << OUT_SHIFT) >> 1);
`endif

   logic signed [AW-1:0]         acc_q, acc_d;
   logic [DECIM_LOG2-1:0]        cnt_q, cnt_d;
   logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                         out_sat_q, out_sat_d;
   logic                         out_valid_q, out_valid_d;
   logic [15:0]                  sat_count_q, sat_count_d;

   logic                         accept;
   logic                         dump;
   logic signed [RW-1:0]         sum_w;
   logic signed [RW-1:0]         rnd_w;
   logic signed [RW-1:0]         shf_w;
   logic signed [DATA_WIDTH-1:0] sat_data_w;
   logic                         sat_flag_w;

   // The dump sample may only land when the output register is free or
   // being drained this cycle; other samples are never stalled.
   assign in_ready = !clear && ((cnt_q != CNT_LAST) || !out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign dump     = accept && (cnt_q == CNT_LAST);

   always_comb begin
      sum_w = {acc_q[AW-1], acc_q}
            + {{(RW - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
`ifdef BOXCAR_DECIMATOR_ROUND_EN
      rnd_w = sum_w + RND_HALF;
`else
      rnd_w = sum_w;
`endif
      shf_w = rnd_w >>> OUT_SHIFT;

      sat_flag_w = 1'b0;
      sat_data_w = shf_w[DATA_WIDTH-1:0];
      if (shf_w > SAT_MAX) begin
         sat_flag_w = 1'b1;
         sat_data_w = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shf_w < SAT_MIN) begin
         sat_flag_w = 1'b1;
         sat_data_w = SAT_MIN[DATA_WIDTH-1:0];
      end
   end

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_valid_d = out_valid_q;
      sat_count_d = sat_count_q;

      if (clear) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         if (dump) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = sum_w[AW-1:0];
            cnt_d = cnt_q + 1'b1;
         end
      end

      // A dump in the same cycle as a drain reloads without a bubble.
      if (dump) begin
         out_data_d  = sat_data_w;
         out_sat_d   = sat_flag_w;
         out_valid_d = 1'b1;
         if (sat_flag_w && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
         sat_count_q <= '0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_valid_q <= out_valid_d;
         sat_count_q <= sat_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign sat_count = sat_count_q;

endmodule

// File: tb/tb_boxcar_decimator.sv
// tb_boxcar_decimator
//   Directed bench for boxcar_decimator. Instance dut uses the defaults
//   (DATA_WIDTH=16, DECIM_LOG2=2, OUT_SHIFT=2); instance dut0 uses OUT_SHIFT=0
//   for the saturation cases. Both share clk and reset.

module tb_boxcar_decimator;

`ifdef BOXCAR_DECIMATOR_ROUND_EN
   localparam logic signed [31:0] EXP_1234 = 3;
   localparam logic signed [31:0] EXP_NEG5 = -1;
`else
   localparam logic signed [31:0] EXP_1234 = 2;
   localparam logic signed [31:0] EXP_NEG5 = -2;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;

   logic               clear = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] in_data = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic signed [15:0] out_data;
   logic               out_sat;
   logic [15:0]        sat_count;

   logic               b_clear = 1'b0;
   logic               b_in_valid = 1'b0;
   logic               b_in_ready;
   logic signed [15:0] b_in_data = '0;
   logic               b_out_valid;
   logic               b_out_ready = 1'b1;
   logic signed [15:0] b_out_data;
   logic               b_out_sat;
   logic [15:0]        b_sat_count;

   int n_checks = 0;
   int n_pass   = 0;

   boxcar_decimator #(.DATA_WIDTH(16), .DECIM_LOG2(2), .OUT_SHIFT(2)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .sat_count(sat_count)
   );

   boxcar_decimator #(.DATA_WIDTH(16), .DECIM_LOG2(2), .OUT_SHIFT(0)) dut0 (
      .clk(clk), .reset(reset), .clear(b_clear),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_sat(b_out_sat), .sat_count(b_sat_count)
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // One sample on dut, accepted on the next edge; returns #1 after it.
   task automatic send(input logic signed [15:0] x);
      in_valid = 1'b1;
      in_data  = x;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_b(input logic signed [15:0] x);
      b_in_valid = 1'b1;
      b_in_data  = x;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
   endtask

   logic signed [15:0] neg_vec [4];
   logic signed [15:0] bp_vec  [12];

   initial begin
      neg_vec = '{-16'sd1, -16'sd1, -16'sd1, -16'sd2};
      bp_vec  = '{16'sd10, 16'sd20, 16'sd30, 16'sd40,
                  16'sd100, 16'sd200, 16'sd300, 16'sd400,
                  -16'sd8, -16'sd8, -16'sd8, -16'sd8};

      // Reset state
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_sat", 32'(out_sat), 0);
      check("rst_satcnt", 32'(sat_count), 0);
      check("rst_ready", 32'(in_ready), 1);
      check("rst_ready_b", 32'(b_in_ready), 1);

      // 1,2,3,4 -> sum 10
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         send(16'(k));
         if (k < 4) check("lat_novalid", 32'(out_valid), 0);
      end
      check("g1234_valid", 32'(out_valid), 1);
      check("g1234_data", 32'(out_data), EXP_1234);
      check("g1234_sat", 32'(out_sat), 0);
      @(posedge clk); #1;
      check("g1234_drain", 32'(out_valid), 0);

      // -1,-1,-1,-2 -> sum -5
      for (int k = 0; k < 4; k++) send(neg_vec[k]);
      check("neg_valid", 32'(out_valid), 1);
      check("neg_data", 32'(out_data), EXP_NEG5);
      @(posedge clk); #1;
      check("neg_drain", 32'(out_valid), 0);

      // OUT_SHIFT=0 saturation
      for (int k = 0; k < 4; k++) send_b(16'sd32767);
      check("satp_valid", 32'(b_out_valid), 1);
      check("satp_data", 32'(b_out_data), 32767);
      check("satp_sat", 32'(b_out_sat), 1);
      check("satp_cnt", 32'(b_sat_count), 1);
      for (int k = 0; k < 4; k++) send_b(-16'sd32768);
      check("satn_data", 32'(b_out_data), -32768);
      check("satn_sat", 32'(b_out_sat), 1);
      check("satn_cnt", 32'(b_sat_count), 2);

      // Backpressure
      out_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
         in_valid = 1'b1;
         in_data  = bp_vec[k];
         #1 check("bp_ready", 32'(in_ready), 1);
         @(posedge clk); #1;
      end
      check("bp_g1_valid", 32'(out_valid), 1);
      check("bp_g1_data", 32'(out_data), 25);
      in_data = bp_vec[7];
      #1 check("bp_stall", 32'(in_ready), 0);
      @(posedge clk); #1;
      check("bp_hold_data", 32'(out_data), 25);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_stall2", 32'(in_ready), 0);
      out_ready = 1'b1;
      #1 check("bp_release", 32'(in_ready), 1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_g2_valid", 32'(out_valid), 1);
      check("bp_g2_data", 32'(out_data), 250);
      for (int k = 8; k < 11; k++) begin
         in_data = bp_vec[k];
         @(posedge clk); #1;
      end
      in_data = bp_vec[11];
      #1 check("bp_stall3", 32'(in_ready), 0);
      check("bp_g2_hold", 32'(out_data), 250);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_g3_valid", 32'(out_valid), 1);
      check("bp_g3_data", 32'(out_data), -8);
      @(posedge clk); #1;
      check("bp_drain", 32'(out_valid), 0);

      // clear discards the partial group 5,5
      send(16'sd5);
      send(16'sd5);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'sd8;
      #1 check("clr_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) send(16'sd8);
      check("clr_novalid", 32'(out_valid), 0);
      send(16'sd8);
      check("clr_valid", 32'(out_valid), 1);
      check("clr_data", 32'(out_data), 8);
      @(posedge clk); #1;

      // reset with pending output and partial group
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(16'sd1);
      check("prst_pending", 32'(out_valid), 1);
      check("prst_data", 32'(out_data), 1);
      for (int k = 0; k < 3; k++) send(16'sd7);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("mrst_valid", 32'(out_valid), 0);
      check("mrst_data", 32'(out_data), 0);
      check("mrst_sat", 32'(out_sat), 0);
      check("mrst_ready", 32'(in_ready), 1);
      check("mrst_satcnt_b", 32'(b_sat_count), 0);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) send(16'sd4);
      check("post_valid", 32'(out_valid), 1);
      check("post_data", 32'(out_data), 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/boxcar_decimator.md
# boxcar_decimator

Streaming accumulate-and-dump decimator. It sits directly downstream of the scaling/clipping front end and consumes one signed sample per accepted handshake. Each group of 2^DECIM_LOG2 samples is summed and emitted as one shifted, saturated output word. The output feeds the derivative/integration stages at the reduced rate.

## Interface
- DATA_WIDTH, 16: input sample width, signed two's complement.
- DECIM_LOG2, 2: log2 of the decimation ratio; N = 2^DECIM_LOG2 samples per output. Legal range 1..8.
- OUT_SHIFT, DECIM_LOG2: arithmetic right shift applied to the group sum. Legal range 0..DECIM_LOG2. A value below DECIM_LOG2 gives a gain of 2^(DECIM_LOG2-OUT_SHIFT).
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous; discards the partial group.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  DATA_WIDTH  signed input sample.
- out_valid  out  1  out_data/out_sat valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_data  out  DATA_WIDTH  signed decimated sample.
- out_sat  out  1  out_data was clipped to full scale.
- sat_count  out  16  number of saturated outputs produced since reset; sticks at 16'hFFFF.

## Operation
- Internal state:
  - acc: signed, DATA_WIDTH+DECIM_LOG2 bits.
  - cnt: DECIM_LOG2 bits, counts 0..N-1.
  - Output register: out_data, out_sat, out_valid.
- Accept is defined as in_valid && in_ready.
- Accept with cnt < N-1: acc <= acc + in_data (sign-extended); cnt <= cnt+1.
- Accept with cnt == N-1 (the dump):
  - sum = acc + in_data.
  - res = sum >>> OUT_SHIFT, arithmetic shift.
  - res is saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. out_sat = 1 if clipped.
  - The output register is loaded and out_valid <= 1.
  - acc <= 0; cnt <= 0.
  - sat_count increments if out_sat is set, unless it is already 16'hFFFF.
- in_ready = !clear && (cnt != N-1 || !out_valid || out_ready). Non-dump samples are never stalled. The dump sample stalls only while an undrained output is pending.
- When out_valid && out_ready and no dump occurs in the same cycle: out_valid <= 0.
- When out_valid && out_ready and a dump occurs in the same cycle: the output register reloads and out_valid stays 1, so there is no bubble.
- While out_valid && !out_ready: out_data and out_sat are held stable. in_valid must be held with in_data stable until accepted.
- clear:
  - acc <= 0; cnt <= 0.
  - in_ready is 0 that cycle, so no sample is accepted.
  - A pending output and sat_count are untouched.
- Reset values: out_valid 0, out_data 0, out_sat 0, sat_count 0, acc 0, cnt 0. in_ready is 1 in the first cycle after reset.
- Reset asserted mid-group or with an output pending drops both, with no output emitted. Reset has priority over clear and over any handshake.

## Timing
- Latency: out_valid rises on the clock edge that accepts the Nth sample of a group. The output is visible the cycle after that accept.
- Sustained throughput: 1 input per cycle, 1 output per N cycles when out_ready=1.
- Datapath: acc add → shift → saturate is a single combinational stage into the output register. There is no combinational path from in_valid to out_valid.
- in_ready depends combinationally on out_ready, out_valid, cnt and clear only.

## Configuration
- Macro: BOXCAR_DECIMATOR_ROUND_EN.
- Defined, with OUT_SHIFT > 0: sum + 2^(OUT_SHIFT-1) is formed at DATA_WIDTH+DECIM_LOG2+1 bits before the shift. This gives round-half-up toward +inf.
- Not defined, or OUT_SHIFT == 0: plain arithmetic shift, which truncates toward -inf.
- Saturation is applied after rounding in both builds.

## Test plan
All scenarios use the defaults (DATA_WIDTH=16, DECIM_LOG2=2, OUT_SHIFT=2) unless stated otherwise.
- Samples 1,2,3,4 with out_ready=1 → one output. Value is 2 without the macro and 3 with it. out_sat=0. out_valid appears the cycle after the 4th accept.
- Samples -1,-1,-1,-2 (sum -5) → output -2 without the macro, -1 with it.
- OUT_SHIFT=0, four samples of 32767 → output 32767, out_sat=1, sat_count=1. Then four samples of -32768 → output -32768, sat_count=2.
- Backpressure:
  - Setup: out_ready=0 and 12 samples driven back-to-back.
  - Required: in_ready drops exactly at the 8th sample; first output held stable.
  - Then: one cycle of out_ready=1 → the 8th sample is accepted in that same cycle, out_valid stays 1 and the second group's value appears.
- clear asserted after 2 samples (5,5), then samples 8,8,8,8 → output 8. The clear cycle shows in_ready=0.
- reset asserted after 3 samples with a pending unread output → every output is 0 and in_ready=1 the next cycle. Samples 4,4,4,4 then give output 4.
